// File: rtl/vga_draw_pkg.sv
// Shared constants and types for the VGA drawing path: screen geometry,
// field widths, palette and the block-draw FSM states.
package vga_draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int TILE     = 5;

    localparam logic [COLOUR_W-1:0] FLOOR  = 3'b000;
    localparam logic [COLOUR_W-1:0] WALL   = 3'b111;
    localparam logic [COLOUR_W-1:0] LOSE   = 3'b100;
    localparam logic [COLOUR_W-1:0] WIN    = 3'b010;
    localparam logic [COLOUR_W-1:0] PLAYER = 3'b001;

    typedef enum logic {
        IDLE,
        DRAW
    } draw_state_t;

    // Coordinates carry one extra bit so a block hanging past the edge
    // cannot wrap back onto the visible area.
    function automatic logic on_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
        return (x < (X_W+1)'(SCREEN_W)) && (y < (Y_W+1)'(SCREEN_H));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: searches last+1, last+2, ... mod NREQ
// and returns the first requester found as one-hot plus its index.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        idx        = '0;
        // Walk from the farthest candidate to the nearest so the nearest hit overrides.
        for (int off = NREQ; off >= 1; off--) begin
            idx = IDX_W'((int'(last) + off) % NREQ);
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
                winner_idx  = idx;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_plot_arbiter.sv
// Shares the VGA adapter write port among several block requesters; each grant
// expands one TILE x TILE block into single-pixel plots, paced by step and clipped.
module block_plot_arbiter #(
    parameter int NREQ = 3,
    parameter int TILE = vga_draw_pkg::TILE
) (
    input  logic                                   clock,
    input  logic                                   resetn,
    input  logic [NREQ-1:0]                        req,
    input  logic [NREQ*vga_draw_pkg::X_W-1:0]      req_x,
    input  logic [NREQ*vga_draw_pkg::Y_W-1:0]      req_y,
    input  logic [NREQ*vga_draw_pkg::COLOUR_W-1:0] req_colour,
    input  logic                                   step,
    output logic [NREQ-1:0]                        gnt,
    output logic [NREQ-1:0]                        done,
    output logic                                   busy,
    output logic [vga_draw_pkg::X_W-1:0]           x_out,
    output logic [vga_draw_pkg::Y_W-1:0]           y_out,
    output logic [vga_draw_pkg::COLOUR_W-1:0]      colour,
    output logic                                   plot
);

    import vga_draw_pkg::*;

    localparam int LAST_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W  = (TILE > 1) ? $clog2(TILE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TILE - 1);
    localparam logic [LAST_W-1:0] LAST_RESET = LAST_W'(NREQ - 1);

    draw_state_t          state;
    logic [LAST_W-1:0]    last;
    logic [NREQ-1:0]      owner;
    logic [X_W-1:0]       ox;
    logic [Y_W-1:0]       oy;
    logic [COLOUR_W-1:0]  oc;
    logic [CNT_W-1:0]     cx;
    logic [CNT_W-1:0]     cy;

    logic [NREQ-1:0]      pick;
    logic [LAST_W-1:0]    pick_idx;
    logic                 pick_valid;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [COLOUR_W-1:0]  sel_colour;
    logic [X_W:0]         pix_x;
    logic [Y_W:0]         pix_y;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (LAST_W)
    ) u_rr_pick (
        .req        (req),
        .last       (last),
        .winner     (pick),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // One-hot AND-OR mux of the winner's origin and colour.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                sel_x      = req_x[i*X_W +: X_W];
                sel_y      = req_y[i*Y_W +: Y_W];
                sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign pix_x = {1'b0, ox} + {{(X_W + 1 - CNT_W){1'b0}}, cx};
    assign pix_y = {1'b0, oy} + {{(Y_W + 1 - CNT_W){1'b0}}, cy};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            last   <= LAST_RESET;
            owner  <= '0;
            ox     <= '0;
            oy     <= '0;
            oc     <= '0;
            cx     <= '0;
            cy     <= '0;
            gnt    <= '0;
            done   <= '0;
            busy   <= 1'b0;
            x_out  <= '0;
            y_out  <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
            gnt  <= '0;
            done <= '0;
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        ox    <= sel_x;
                        oy    <= sel_y;
                        oc    <= sel_colour;
                        cx    <= '0;
                        cy    <= '0;
                        last  <= pick_idx;
                        owner <= pick;
                        gnt   <= pick;
                        busy  <= 1'b1;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (step) begin
                        // Off-screen pixels still consume a step but leave the port untouched.
                        if (on_screen(pix_x, pix_y)) begin
                            x_out  <= pix_x[X_W-1:0];
                            y_out  <= pix_y[Y_W-1:0];
                            colour <= oc;
                            plot   <= 1'b1;
                        end
                        if (cx == CNT_LAST) begin
                            cx <= '0;
                            if (cy == CNT_LAST) begin
                                done  <= owner;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                cy <= cy + 1'b1;
                            end
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_plot_arbiter.sv
// Scoreboard bench for block_plot_arbiter: a transaction-level model predicts
// grants, pixels and done pulses; a monitor compares them as the DUT emits them.
module tb_block_plot_arbiter;

    import vga_draw_pkg::*;

    localparam int NREQ = 3;
    localparam int NPIX = TILE * TILE;

    typedef struct {int x; int y; int c;} job_t;
    typedef struct {int cyc; int idx;} ev_t;
    typedef struct {int cyc; int x; int y; int c;} pix_t;

    logic                     clock = 1'b0;
    logic                     resetn = 1'b1;
    logic [NREQ-1:0]          req = '0;
    logic [NREQ*X_W-1:0]      req_x = '0;
    logic [NREQ*Y_W-1:0]      req_y = '0;
    logic [NREQ*COLOUR_W-1:0] req_colour = '0;
    logic                     step = 1'b0;
    logic [NREQ-1:0]          gnt;
    logic [NREQ-1:0]          done;
    logic                     busy;
    logic [X_W-1:0]           x_out;
    logic [Y_W-1:0]           y_out;
    logic [COLOUR_W-1:0]      colour;
    logic                     plot;

    job_t jobs[NREQ][$];
    ev_t  gnt_q[$];
    ev_t  done_q[$];
    pix_t pix_q[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int plots_seen = 0;
    int step_mode = 0;

    block_plot_arbiter #(.NREQ(NREQ), .TILE(TILE)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .step       (step),
        .gnt        (gnt),
        .done       (done),
        .busy       (busy),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour     (colour),
        .plot       (plot)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_job(input int i, input int x, input int y, input int c);
        job_t j;
        j.x = x; j.y = y; j.c = c;
        jobs[i].push_back(j);
    endtask

    // Requester agents: present queued jobs, drop or reload req on gnt, scramble idle inputs.
    initial begin
        int step_cnt;
        job_t j;
        step_cnt = 0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                for (int i = 0; i < NREQ; i++) jobs[i].delete();
                req = '0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt[i] || !req[i]) begin
                        if (jobs[i].size() != 0) begin
                            j = jobs[i].pop_front();
                            req_x[i*X_W +: X_W]                = X_W'(j.x);
                            req_y[i*Y_W +: Y_W]                = Y_W'(j.y);
                            req_colour[i*COLOUR_W +: COLOUR_W] = COLOUR_W'(j.c);
                            req[i] = 1'b1;
                        end else begin
                            req[i] = 1'b0;
                            req_x[i*X_W +: X_W]                = X_W'($urandom);
                            req_y[i*Y_W +: Y_W]                = Y_W'($urandom);
                            req_colour[i*COLOUR_W +: COLOUR_W] = COLOUR_W'($urandom);
                        end
                    end
                end
            end
            case (step_mode)
                0:       step = 1'b1;
                1:       step = (step_cnt % 3 == 0);
                default: step = 1'($urandom_range(0, 1));
            endcase
            step_cnt++;
        end
    end

    // Reference model: arbiter is free or drawing; a block ends after its 25th step.
    initial begin
        bit m_busy;
        int m_last, m_win, m_k, m_ox, m_oy, m_c, px, py;
        m_busy = 0; m_last = NREQ - 1; m_win = 0; m_k = 0;
        m_ox = 0; m_oy = 0; m_c = 0;
        forever begin
            @(posedge clock or negedge resetn);
            if (!resetn) begin
                gnt_q.delete(); pix_q.delete(); done_q.delete();
                m_busy = 0; m_last = NREQ - 1; m_k = 0;
            end else if (!m_busy) begin
                if (req != '0) begin
                    m_win = -1;
                    for (int k = 1; k <= NREQ; k++)
                        if (m_win < 0 && req[(m_last + k) % NREQ]) m_win = (m_last + k) % NREQ;
                    m_ox = int'(req_x[m_win*X_W +: X_W]);
                    m_oy = int'(req_y[m_win*Y_W +: Y_W]);
                    m_c  = int'(req_colour[m_win*COLOUR_W +: COLOUR_W]);
                    gnt_q.push_back('{cyc + 1, m_win});
                    m_last = m_win; m_busy = 1; m_k = 0;
                end
            end else if (step) begin
                px = m_ox + m_k % TILE;
                py = m_oy + m_k / TILE;
                if (px < SCREEN_W && py < SCREEN_H) pix_q.push_back('{cyc + 1, px, py, m_c});
                if (m_k == NPIX - 1) begin
                    done_q.push_back('{cyc + 1, m_win});
                    m_busy = 0;
                end
                m_k++;
            end
        end
    end

    // Monitor: compare whatever the DUT presents against the predicted events.
    initial begin
        ev_t e;
        pix_t p;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge clock);
            if (resetn) begin
                if (gnt_q.size() != 0 && gnt_q[0].cyc == cyc) begin
                    e = gnt_q.pop_front();
                    oh = '0; oh[e.idx] = 1'b1;
                    check("gnt", 64'({gnt, busy}), 64'({oh, 1'b1}));
                end else if (gnt != '0) begin
                    check("gnt_unexpected", 64'(gnt), 64'(0));
                end
                if (pix_q.size() != 0 && pix_q[0].cyc == cyc) begin
                    p = pix_q.pop_front();
                    check("pixel", 64'({plot, x_out, y_out, colour}),
                          64'({1'b1, X_W'(p.x), Y_W'(p.y), COLOUR_W'(p.c)}));
                end else if (plot) begin
                    check("plot_unexpected", 64'(plot), 64'(0));
                end
                if (plot) plots_seen++;
                if (done_q.size() != 0 && done_q[0].cyc == cyc) begin
                    e = done_q.pop_front();
                    oh = '0; oh[e.idx] = 1'b1;
                    check("done", 64'({done, busy}), 64'({oh, 1'b0}));
                end else if (done != '0) begin
                    check("done_unexpected", 64'(done), 64'(0));
                end
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        #1 check("reset_outputs", 64'({gnt, done, busy, x_out, y_out, colour, plot}), 64'(0));
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && (jobs[0].size() != 0 || jobs[1].size() != 0 || jobs[2].size() != 0 ||
               req != '0 || busy || gnt_q.size() != 0 || pix_q.size() != 0 || done_q.size() != 0)) begin
            @(negedge clock);
            #1 n++;
        end
        check("drain_idle", 64'({req, busy}), 64'(0));
    endtask

    initial begin
        int base, n;
        #1 do_reset();

        // Single block at the origin, full rate.
        step_mode = 0;
        push_job(0, 0, 0, int'(WALL));
        drain(200);

        // All three requesting together straight out of reset: order 0,1,2,0,1.
        @(negedge clock);
        #2 do_reset();
        push_job(0, 5, 5, int'(WALL));
        push_job(0, 30, 5, int'(FLOOR));
        push_job(1, 10, 10, int'(PLAYER));
        push_job(1, 35, 10, int'(WIN));
        push_job(2, 15, 20, int'(LOSE));
        drain(600);

        // Step one cycle in three.
        step_mode = 1;
        push_job(2, 20, 15, int'(PLAYER));
        drain(400);

        // Corner clip: only 6 of 25 pixels visible.
        step_mode = 0;
        push_job(1, 157, 118, int'(WIN));
        drain(200);

        // Reset after 10 plots of a block; next grant must go to requester 0.
        base = plots_seen;
        push_job(0, 40, 40, int'(WALL));
        n = 0;
        while (plots_seen < base + 10 && n < 200) begin
            @(negedge clock);
            #1 n++;
        end
        check("mid_block_plots", 64'(plots_seen - base), 64'(10));
        do_reset();
        push_job(2, 60, 60, int'(LOSE));
        push_job(0, 70, 30, int'(WIN));
        drain(300);

        // req2 rises while requester 0 is drawing.
        push_job(0, 100, 50, int'(WALL));
        repeat (6) @(negedge clock);
        push_job(2, 10, 100, int'(LOSE));
        drain(300);

        // Random blocks, random pacing, edges favoured.
        step_mode = 2;
        for (int j = 0; j < 30; j++) begin
            push_job(int'($urandom_range(0, NREQ - 1)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 155)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 115)),
                     int'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 20)) @(negedge clock);
        end
        drain(20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
